// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// BTB entry kinds, resolve-type encodings, counter constants, link-register test.
package bp_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    RETURN = 2'd2
  } btb_kind_e;

  localparam logic [1:0] EX_NONE = 2'd0;
  localparam logic [1:0] EX_BR   = 2'd1;
  localparam logic [1:0] EX_JAL  = 2'd2;
  localparam logic [1:0] EX_JALR = 2'd3;

  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Non-speculative circular return-address stack.
// Overflow overwrites the oldest entry; a pop on an empty stack is ignored.
import bp_pkg::*;

module bp_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] stk_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   wr_idx;
  logic            wr_en;
  logic            do_pop;

  assign top_idx = ptr_q - PW'(1);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign top_o   = stk_q[top_idx];
  assign empty_o = (cnt_q == '0);

  // Next pointer/count and write slot for push, pop and pop-push
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (do_pop && push_i) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Stack pointer, occupancy and entry storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) begin
        stk_q[wr_idx] <= data_i;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB, bimodal 2-bit counters,
// optional return-address stack (enabled by defining RAS_EN).
import bp_pkg::*;

module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_pc_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [1:0]      ex_type_i,
  input  logic [4:0]      ex_rd_i,
  input  logic [4:0]      ex_rs1_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_pc_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int TAG_W  = XLEN - BTB_IW - 2;

  logic             btb_v_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q  [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_q  [BTB_ENTRIES];
  btb_kind_e        btb_kind_q [BTB_ENTRIES];
  logic [1:0]       bht_q      [BHT_ENTRIES];

  logic [BTB_IW-1:0] if_bi, ex_bi;
  logic [BHT_IW-1:0] if_hi, ex_hi;
  logic [TAG_W-1:0]  if_tag, ex_tag;
  logic [XLEN-1:0]   if_seq, ex_seq;

  assign if_bi  = if_pc_i[BTB_IW+1:2];
  assign ex_bi  = ex_pc_i[BTB_IW+1:2];
  assign if_hi  = if_pc_i[BHT_IW+1:2];
  assign ex_hi  = ex_pc_i[BHT_IW+1:2];
  assign if_tag = if_pc_i[XLEN-1:BTB_IW+2];
  assign ex_tag = ex_pc_i[XLEN-1:BTB_IW+2];
  assign if_seq = if_pc_i + XLEN'(4);
  assign ex_seq = ex_pc_i + XLEN'(4);

  logic      ex_ctl;
  logic      is_jump;
  logic      is_ret;
  btb_kind_e new_kind;
  logic [1:0] ctr, ctr_nxt;

  assign ex_ctl  = ex_valid_i && (ex_type_i != EX_NONE);
  assign is_jump = (ex_type_i == EX_JAL) || (ex_type_i == EX_JALR);
  assign is_ret  = (ex_type_i == EX_JALR)
                && is_link_reg(ex_rs1_i)
                && (ex_rs1_i != ex_rd_i);

  // Resolve: flush request and corrected fetch PC
  always_comb begin
    mispredict_o  = ex_ctl &&
                    ((ex_taken_i != ex_pred_taken_i) ||
                     (ex_taken_i && (ex_target_i != ex_pred_pc_i)));
    redirect_pc_o = ex_taken_i ? ex_target_i : ex_seq;
  end

  // Kind stored on allocation and saturating counter step
  always_comb begin
    new_kind = BRANCH;
    if (is_ret) begin
      new_kind = RETURN;
    end else if (is_jump) begin
      new_kind = JUMP;
    end
    ctr     = bht_q[ex_hi];
    ctr_nxt = ctr;
    if (ex_taken_i) begin
      if (ctr != ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_nxt = ctr - 2'd1;
    end
  end

  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

`ifdef RAS_EN
  logic is_call;
  assign is_call = is_jump && is_link_reg(ex_rd_i);

  bp_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ex_ctl && is_call),
    .pop_i   (ex_ctl && is_ret),
    .data_i  (ex_seq),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );
`else
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
`endif

  logic btb_hit;
  logic use_ras;

  // Lookup: BTB hit qualified by kind and counter MSB
  always_comb begin
    btb_hit = btb_v_q[if_bi] && (btb_tag_q[if_bi] == if_tag);
    use_ras = (btb_kind_q[if_bi] == RETURN) && !ras_empty;
    pred_taken_o = 1'b0;
    pred_pc_o    = if_seq;
    if (if_valid_i && btb_hit) begin
      if ((btb_kind_q[if_bi] != BRANCH) || bht_q[if_hi][1]) begin
        pred_taken_o = 1'b1;
        pred_pc_o    = use_ras ? ras_top : btb_tgt_q[if_bi];
      end
    end
  end

  // Bimodal counters trained by resolved conditional branches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= WNT;
      end
    end else if (ex_ctl && (ex_type_i == EX_BR)) begin
      bht_q[ex_hi] <= ctr_nxt;
    end
  end

  // BTB allocation/overwrite for every taken control transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_v_q[i]    <= 1'b0;
        btb_tag_q[i]  <= '0;
        btb_tgt_q[i]  <= '0;
        btb_kind_q[i] <= BRANCH;
      end
    end else if (ex_ctl && ex_taken_i) begin
      btb_v_q[ex_bi]    <= 1'b1;
      btb_tag_q[ex_bi]  <= ex_tag;
      btb_tgt_q[ex_bi]  <= ex_target_i;
      btb_kind_q[ex_bi] <= new_kind;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// RAS sequence is exercised when RAS_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_type;
  logic [4:0]  ex_rd, ex_rs1;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int vecs = 0;
  int errs = 0;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_BR   = 2'd1;
  localparam logic [1:0] T_JAL  = 2'd2;
  localparam logic [1:0] T_JALR = 2'd3;

  always #5 clk = ~clk;

  branch_predictor #(
    .XLEN(32), .BTB_ENTRIES(16), .BHT_ENTRIES(64), .RAS_DEPTH(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_valid_i      (if_valid),
    .if_pc_i         (if_pc),
    .pred_taken_o    (pred_taken),
    .pred_pc_o       (pred_pc),
    .ex_valid_i      (ex_valid),
    .ex_pc_i         (ex_pc),
    .ex_type_i       (ex_type),
    .ex_rd_i         (ex_rd),
    .ex_rs1_i        (ex_rs1),
    .ex_taken_i      (ex_taken),
    .ex_target_i     (ex_target),
    .ex_pred_taken_i (ex_pred_taken),
    .ex_pred_pc_i    (ex_pred_pc),
    .mispredict_o    (mispredict),
    .redirect_pc_o   (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic et,
                      input logic [31:0] epc, input string tag);
    if_valid = 1'b1;
    if_pc    = pc;
    #1;
    chk({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, et});
    chk({tag, "_pc"}, pred_pc, epc);
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [1:0] ty,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic tk, input logic [31:0] tgt);
    ex_valid  = 1'b1;
    ex_pc     = pc;
    ex_type   = ty;
    ex_rd     = rd;
    ex_rs1    = rs1;
    ex_taken  = tk;
    ex_target = tgt;
  endtask

  task automatic train(input logic [31:0] pc, input logic [1:0] ty,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic tk, input logic [31:0] tgt);
    set_ex(pc, ty, rd, rs1, tk, tgt);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic mp(input logic v, input logic [1:0] ty,
                    input logic [31:0] pc, input logic tk,
                    input logic [31:0] tgt, input logic ptk,
                    input logic [31:0] ppc, input logic em,
                    input logic [31:0] erd, input string tag);
    ex_valid      = v;
    ex_type       = ty;
    ex_pc         = pc;
    ex_taken      = tk;
    ex_target     = tgt;
    ex_pred_taken = ptk;
    ex_pred_pc    = ppc;
    #1;
    chk({tag, "_mis"}, {31'b0, mispredict}, {31'b0, em});
    chk({tag, "_redir"}, redirect_pc, erd);
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; if_pc = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_type = T_NONE;
    ex_rd = '0; ex_rs1 = '0; ex_taken = 1'b0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look(32'h100, 1'b0, 32'h104, "reset_lookup");
    look(32'hFFFF_FFFC, 1'b0, 32'h0, "pc_wrap");

    // counter: 01 ->10 ->11 ->11
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b1, 32'h180);
    look(32'h200, 1'b1, 32'h180, "ctr_10");
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b1, 32'h180);
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b1, 32'h180);
    look(32'h200, 1'b1, 32'h180, "ctr_11");
    if_valid = 1'b0;
    #1;
    chk("ifv_low_taken", {31'b0, pred_taken}, 32'h0);
    chk("ifv_low_pc", pred_pc, 32'h204);
    // 11 ->10 ->01 ->00, then 00 ->01 ->10
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b0, 32'h0);
    look(32'h200, 1'b1, 32'h180, "ctr_dn_10");
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b0, 32'h0);
    look(32'h200, 1'b0, 32'h204, "ctr_dn_01");
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b0, 32'h0);
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b1, 32'h180);
    look(32'h200, 1'b0, 32'h204, "ctr_up_01");
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b1, 32'h180);
    look(32'h200, 1'b1, 32'h180, "ctr_up_10");

    @(posedge clk);
    #1;
    mp(1'b1, T_BR, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304,
       1'b1, 32'h400, "mp_dir_t");
    mp(1'b1, T_BR, 32'h300, 1'b0, 32'h400, 1'b1, 32'h400,
       1'b1, 32'h304, "mp_dir_nt");
    mp(1'b1, T_BR, 32'h300, 1'b1, 32'h400, 1'b1, 32'h400,
       1'b0, 32'h400, "mp_ok");
    mp(1'b1, T_JALR, 32'h300, 1'b1, 32'h400, 1'b1, 32'h500,
       1'b1, 32'h400, "mp_tgt");
    mp(1'b1, T_NONE, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304,
       1'b0, 32'h400, "mp_none");
    mp(1'b0, T_BR, 32'hFFFF_FFFC, 1'b0, 32'h400, 1'b1, 32'h400,
       1'b0, 32'h0, "mp_wrap");
    ex_valid = 1'b0;

    // alias: 0x40 and 0x80 share BTB index 0
    train(32'h40, T_JAL, 5'd0, 5'd0, 1'b1, 32'h800);
    look(32'h40, 1'b1, 32'h800, "alias_a");
    set_ex(32'h80, T_JAL, 5'd0, 5'd0, 1'b1, 32'h900);
    look(32'h80, 1'b0, 32'h84, "no_bypass");
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    look(32'h40, 1'b0, 32'h44, "alias_evict");
    look(32'h80, 1'b1, 32'h900, "alias_b");

`ifdef RAS_EN
    train(32'h10, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    train(32'h20, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    train(32'h30, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    train(32'h40, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    train(32'h50, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    // return resolve pops 0x54; re-call refills it
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'h54);
    train(32'h50, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    look(32'h600, 1'b1, 32'h54, "ras_0");
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'h54);
    look(32'h600, 1'b1, 32'h44, "ras_1");
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'h44);
    look(32'h600, 1'b1, 32'h34, "ras_2");
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'h34);
    look(32'h600, 1'b1, 32'h24, "ras_3");
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'h24);
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'hABC);
    look(32'h600, 1'b1, 32'hABC, "ras_underflow");
    train(32'h50, T_JAL, 5'd1, 5'd0, 1'b1, 32'h1000);
    look(32'h600, 1'b1, 32'h54, "ras_after_uf");
`else
    train(32'h600, T_JALR, 5'd0, 5'd1, 1'b1, 32'h654);
    look(32'h600, 1'b1, 32'h654, "ret_btb");
`endif

    // reset mid-run
    train(32'h700, T_JAL, 5'd0, 5'd0, 1'b1, 32'h780);
    look(32'h700, 1'b1, 32'h780, "pre_rst");
    @(posedge clk);
    #1;
    set_ex(32'h704, T_JAL, 5'd0, 5'd0, 1'b1, 32'h790);
    #2 rst = 1'b1;
    look(32'h700, 1'b0, 32'h704, "rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    look(32'h704, 1'b0, 32'h708, "rst_discard");
    look(32'h700, 1'b0, 32'h704, "rst_cleared");
    train(32'h200, T_BR, 5'd0, 5'd0, 1'b1, 32'h180);
    look(32'h200, 1'b1, 32'h180, "ctr_rst_wnt");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
